// File: rtl/decoded_register_bank.sv
// Write-decoded bank of 32 N-bit enabled registers with one combinational read port (RV32 regfile core).
// Latency: writes visible one clk edge after capture; reads and decoder outputs are combinational.
// Backpressure: none; a write is accepted on every edge where wr_ena is high. Option: HARDWIRED_ZERO_EN.
module decoded_register_bank #(
   parameter int          N           = 32,
   parameter logic [N-1:0] RESET_VALUE = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_ena,
   input  logic [4:0]        wr_addr,
   input  logic [N-1:0]      wr_data,
   input  logic [4:0]        rd_addr,
   output logic [N-1:0]      rd_data,
   output logic [31:0]       wr_enas,
   output logic [32*N-1:0]   q_all
);

`ifdef HARDWIRED_ZERO_EN
   // Slot 0 is the RISC-V x0: it has no flop behind it.
   localparam int FIRST_SLOT = 1;
`else
   localparam int FIRST_SLOT = 0;
`endif

   // Physical storage only for the slots that actually hold state.
   logic [N-1:0] mem  [FIRST_SLOT:31];
   // Architectural view of all 32 slots, including a hardwired slot 0.
   logic [N-1:0] view [32];

   // One-hot write-enable decoder; independent of reset.
   always_comb begin
      wr_enas = 32'b0;
      if (wr_ena) begin
         wr_enas = 32'b1 << wr_addr;
      end
   end

   // Enabled registers: async reset wins over any write on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = FIRST_SLOT; i < 32; i++) begin
            mem[i] <= RESET_VALUE;
         end
      end else begin
         for (int i = FIRST_SLOT; i < 32; i++) begin
            if (wr_enas[i]) begin
               mem[i] <= wr_data;
            end
         end
      end
   end

   // Build the architectural view; slot 0 reads constant zero when hardwired.
   always_comb begin
      for (int i = 0; i < 32; i++) begin
         view[i] = '0;
      end
      for (int i = FIRST_SLOT; i < 32; i++) begin
         view[i] = mem[i];
      end
   end

   // Combinational read port: every 5-bit address maps to a real slot, no bypass.
   always_comb begin
      rd_data = view[rd_addr];
   end

   // Flatten all slots onto q_all, slot k at bits [k*N +: N].
   always_comb begin
      q_all = '0;
      for (int i = 0; i < 32; i++) begin
         q_all[i*N +: N] = view[i];
      end
   end

endmodule

// File: tb/tb_decoded_register_bank.sv
// Self-checking bench for decoded_register_bank (N=32, RESET_VALUE=0).
// Directed steps followed by randomized write/read traffic against an array model.
// Build with +define+HARDWIRED_ZERO_EN to check the hardwired x0 variant.
module tb_decoded_register_bank;

   localparam int N = 32;

   logic            clk;
   logic            rst;
   logic            wr_ena;
   logic [4:0]      wr_addr;
   logic [N-1:0]    wr_data;
   logic [4:0]      rd_addr;
   logic [N-1:0]    rd_data;
   logic [31:0]     wr_enas;
   logic [32*N-1:0] q_all;

   int compared = 0;
   int failed   = 0;

   // Reference model: what each slot was last written with (or reset to).
   logic [N-1:0] model [32];

   decoded_register_bank #(.N(N), .RESET_VALUE('0)) dut (
      .clk     (clk),
      .rst     (rst),
      .wr_ena  (wr_ena),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .wr_enas (wr_enas),
      .q_all   (q_all)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Architectural read of slot a as the program sees it.
   function automatic logic [N-1:0] exp_rd(input int a);
`ifdef HARDWIRED_ZERO_EN
      if (a == 0) return '0;
`endif
      return model[a];
   endfunction

   function automatic logic [32*N-1:0] exp_all();
      logic [32*N-1:0] v;
      v = '0;
      for (int k = 0; k < 32; k++) v[k*N +: N] = exp_rd(k);
      return v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 32; k++) model[k] = '0;
   endtask

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [32*N-1:0] e;
      e = exp_all();
      compared++;
      assert (q_all === e) else begin
         failed++;
         $error("FAIL %s q_all observed=%h expected=%h", tag, q_all, e);
      end
   endtask

   // Single write: set up on the falling edge, captured on the next rising edge.
   task automatic do_write(input logic [4:0] a, input logic [N-1:0] d);
      @(negedge clk);
      wr_ena  = 1'b1;
      wr_addr = a;
      wr_data = d;
      @(posedge clk);
      model[a] = d;
      #1;
      wr_ena = 1'b0;
   endtask

   initial begin
      logic [31:0] one_hot;
      logic [N-1:0] old_v;
      rst = 1'b1; wr_ena = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
      model_reset();

      // Reset state.
      #2;
      check_all("reset_state");
      check32("reset_wr_enas_idle", wr_enas, 32'h0);

      // Decoder sweep while held in reset, so nothing is written.
      for (int k = 0; k < 32; k++) begin
         wr_ena  = 1'b1;
         wr_addr = k[4:0];
         one_hot = 32'h1 << k;
         #1;
         check32($sformatf("decode_addr%0d", k), wr_enas, one_hot);
      end
      for (int k = 0; k < 8; k++) begin
         wr_ena  = 1'b0;
         wr_addr = 5'($urandom_range(0, 31));
         #1;
         check32("decode_disabled", wr_enas, 32'h0);
      end
      check_all("sweep_in_reset_no_write");

      // Release reset, preload every slot with 0xDEADBEEF.
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 32; k++) do_write(k[4:0], 32'hDEADBEEF);
      check_all("preload");

      // Mid-cycle asynchronous reset clears everything before the next edge.
      @(negedge clk);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_all("async_reset_midcycle");
      rd_addr = 5'd9;
      #1;
      check32("async_reset_rd", rd_data, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Write 0x1000+k into slot k, checking the slot and that nothing else moved.
      for (int k = 1; k < 32; k++) begin
         do_write(k[4:0], 32'h1000 + k);
         rd_addr = k[4:0];
         #1;
         check32($sformatf("write_read_slot%0d", k), rd_data, 32'h1000 + k);
         check_all($sformatf("write_isolation_slot%0d", k));
      end

      // Slot 0 write of all ones.
      do_write(5'd0, 32'hFFFFFFFF);
      rd_addr = 5'd0;
      #1;
`ifdef HARDWIRED_ZERO_EN
      check32("slot0_write", rd_data, 32'h0);
`else
      check32("slot0_write", rd_data, 32'hFFFFFFFF);
`endif
      check_all("slot0_q_all");

      // Same-cycle read and write of slot 5: old value before the edge, new after.
      do_write(5'd5, 32'h11);
      @(negedge clk);
      rd_addr = 5'd5;
      wr_ena  = 1'b1;
      wr_addr = 5'd5;
      wr_data = 32'h22;
      #1;
      check32("rw_same_before_edge", rd_data, 32'h11);
      @(posedge clk);
      model[5] = 32'h22;
      #1;
      check32("rw_same_after_edge", rd_data, 32'h22);
      wr_ena = 1'b0;

      // Reset vs write collision on slot 7.
      @(negedge clk);
      rst = 1'b1;
      wr_ena = 1'b1; wr_addr = 5'd7; wr_data = 32'hABCD;
      rd_addr = 5'd7;
      model_reset();
      @(posedge clk);
      #1;
      check32("collision_in_reset", rd_data, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check32("collision_before_first_edge", rd_data, 32'h0);
      @(posedge clk);
      model[7] = 32'hABCD;
      #1;
      check32("collision_after_release", rd_data, 32'hABCD);
      check_all("collision_q_all");
      wr_ena = 1'b0;

      // Randomized traffic against the model.
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         wr_ena  = ($urandom_range(0, 3) != 0);
         wr_addr = 5'($urandom_range(0, 31));
         wr_data = $urandom;
         rd_addr = (($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31)));
         #1;
         check32("rand_rd_before_edge", rd_data, exp_rd(int'(rd_addr)));
         check32("rand_decode", wr_enas, wr_ena ? (32'h1 << wr_addr) : 32'h0);
         @(posedge clk);
         if (wr_ena) model[wr_addr] = wr_data;
         #1;
         check32("rand_rd_after_edge", rd_data, exp_rd(int'(rd_addr)));
         check_all("rand_q_all");
      end
      wr_ena = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
